// File: rtl/usb_device_xact_fsm_if.sv
`default_nettype none
// ============================================================================
// usb_device_xact_fsm_if : packet strobes and transmit commands around the
//                          device-side USB transaction responder
// Revision 1.0
// ============================================================================
interface usb_device_xact_fsm_if;
    logic       token_valid;
    logic [3:0] token_pid;
    logic [6:0] token_addr;
    logic       data_valid;
    logic [3:0] data_pid;
    logic       data_crc_ok;
    logic       hand_valid;
    logic [3:0] hand_pid;
    logic       rx_ready;
    logic       tx_ready;
    logic       start_send_data;
    logic [3:0] send_data_pid;
    logic       done_send_data;
    logic       start_send_hand;
    logic [3:0] send_hand_pid;
    logic       done_send_hand;
    logic       wr_commit;
    logic       rd_commit;

    // master: the transaction responder; slave: PHY codec plus endpoint buffer
    modport master (
        input  token_valid, token_pid, token_addr,
        input  data_valid, data_pid, data_crc_ok,
        input  hand_valid, hand_pid, rx_ready, tx_ready,
        input  done_send_data, done_send_hand,
        output start_send_data, send_data_pid,
        output start_send_hand, send_hand_pid,
        output wr_commit, rd_commit
    );

    modport slave (
        output token_valid, token_pid, token_addr,
        output data_valid, data_pid, data_crc_ok,
        output hand_valid, hand_pid, rx_ready, tx_ready,
        output done_send_data, done_send_hand,
        input  start_send_data, send_data_pid,
        input  start_send_hand, send_hand_pid,
        input  wr_commit, rd_commit
    );
endinterface
`default_nettype wire

// File: rtl/usb_device_xact_fsm.sv
`default_nettype none
// ============================================================================
// usb_device_xact_fsm : device-side USB transaction responder (OUT/IN with
//                       turnaround timeout). Macro USB_TOGGLE_CHECK_EN enables
//                       DATA0/DATA1 toggle tracking and duplicate detection.
// Revision 1.0
// ============================================================================
module usb_device_xact_fsm #(
    parameter logic [6:0] DEV_ADDR       = 7'd5,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  wire logic             clk,
    input  wire logic             rst_l,
    usb_device_xact_fsm_if.master bus
);
    localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] c_timer_last = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] c_timer_one  = TW'(1);
    localparam logic [3:0]    c_pid_out    = 4'b0001;
    localparam logic [3:0]    c_pid_in     = 4'b1001;
    localparam logic [3:0]    c_pid_data0  = 4'b0011;
    localparam logic [3:0]    c_pid_data1  = 4'b1011;
    localparam logic [3:0]    c_pid_ack    = 4'b0010;
    localparam logic [3:0]    c_pid_nak    = 4'b1010;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RX_DATA = 3'd1,
        S_TX_HAND = 3'd2,
        S_TX_DATA = 3'd3,
        S_RX_HAND = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          start_send_data_q, start_send_data_d;
    logic [3:0]    send_data_pid_q, send_data_pid_d;
    logic          start_send_hand_q, start_send_hand_d;
    logic [3:0]    send_hand_pid_q, send_hand_pid_d;
    logic          wr_commit_q, wr_commit_d;
    logic          rd_commit_q, rd_commit_d;

    logic [3:0]    in_data_pid;
    logic          out_pid_match;

`ifdef USB_TOGGLE_CHECK_EN
    logic out_toggle_q, out_toggle_d;
    logic in_toggle_q, in_toggle_d;

    // A toggle flips exactly when its payload is committed
    always_comb begin
        out_toggle_d = out_toggle_q ^ wr_commit_d;
        in_toggle_d  = in_toggle_q ^ rd_commit_d;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            out_toggle_q <= 1'b0;
            in_toggle_q  <= 1'b0;
        end else begin
            out_toggle_q <= out_toggle_d;
            in_toggle_q  <= in_toggle_d;
        end
    end

    assign in_data_pid   = in_toggle_q ? c_pid_data1 : c_pid_data0;
    assign out_pid_match = (bus.data_pid == (out_toggle_q ? c_pid_data1 : c_pid_data0));
`else
    wire logic unused_data_pid = ^bus.data_pid;

    assign in_data_pid   = c_pid_data0;
    assign out_pid_match = 1'b1;
`endif

    always_comb begin
        state_d           = state_q;
        timer_d           = timer_q;
        start_send_data_d = 1'b0;
        start_send_hand_d = 1'b0;
        wr_commit_d       = 1'b0;
        rd_commit_d       = 1'b0;
        send_data_pid_d   = send_data_pid_q;
        send_hand_pid_d   = send_hand_pid_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.token_valid && (bus.token_addr == DEV_ADDR)) begin
                    if (bus.token_pid == c_pid_out) begin
                        state_d = S_RX_DATA;
                        timer_d = '0;
                    end else if (bus.token_pid == c_pid_in) begin
                        if (bus.tx_ready) begin
                            state_d           = S_TX_DATA;
                            start_send_data_d = 1'b1;
                            send_data_pid_d   = in_data_pid;
                        end else begin
                            state_d           = S_TX_HAND;
                            start_send_hand_d = 1'b1;
                            send_hand_pid_d   = c_pid_nak;
                        end
                    end
                end
            end
            S_RX_DATA: begin
                timer_d = timer_q + c_timer_one;
                // A strobe in the last timeout cycle still wins
                if (bus.data_valid) begin
                    if (!bus.data_crc_ok) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d           = S_TX_HAND;
                        start_send_hand_d = 1'b1;
                        if (!bus.rx_ready) begin
                            send_hand_pid_d = c_pid_nak;
                        end else begin
                            send_hand_pid_d = c_pid_ack;
                            wr_commit_d     = out_pid_match;
                        end
                    end
                end else if (timer_q == c_timer_last) begin
                    state_d = S_IDLE;
                end
            end
            S_TX_HAND: begin
                if (bus.done_send_hand) begin
                    state_d         = S_IDLE;
                    send_hand_pid_d = '0;
                end
            end
            S_TX_DATA: begin
                if (bus.done_send_data) begin
                    state_d         = S_RX_HAND;
                    timer_d         = '0;
                    send_data_pid_d = '0;
                end
            end
            S_RX_HAND: begin
                timer_d = timer_q + c_timer_one;
                // Non-ACK leaves the IN toggle alone so the payload is re-sent
                if (bus.hand_valid) begin
                    state_d     = S_IDLE;
                    rd_commit_d = (bus.hand_pid == c_pid_ack);
                end else if (timer_q == c_timer_last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q           <= S_IDLE;
            timer_q           <= '0;
            start_send_data_q <= 1'b0;
            send_data_pid_q   <= '0;
            start_send_hand_q <= 1'b0;
            send_hand_pid_q   <= '0;
            wr_commit_q       <= 1'b0;
            rd_commit_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            timer_q           <= timer_d;
            start_send_data_q <= start_send_data_d;
            send_data_pid_q   <= send_data_pid_d;
            start_send_hand_q <= start_send_hand_d;
            send_hand_pid_q   <= send_hand_pid_d;
            wr_commit_q       <= wr_commit_d;
            rd_commit_q       <= rd_commit_d;
        end
    end

    assign bus.start_send_data = start_send_data_q;
    assign bus.send_data_pid   = send_data_pid_q;
    assign bus.start_send_hand = start_send_hand_q;
    assign bus.send_hand_pid   = send_hand_pid_q;
    assign bus.wr_commit       = wr_commit_q;
    assign bus.rd_commit       = rd_commit_q;
endmodule
`default_nettype wire

// File: tb/tb_usb_device_xact_fsm.sv
`default_nettype none
// ============================================================================
// tb_usb_device_xact_fsm : directed plus randomized transactions against a
//                          transaction-level model of the responder
// Revision 1.0
// ============================================================================
module tb_usb_device_xact_fsm;
    localparam logic [6:0] DEV   = 7'd5;
    localparam int         TO    = 8;
    localparam logic [3:0] P_OUT = 4'b0001;
    localparam logic [3:0] P_IN  = 4'b1001;
    localparam logic [3:0] P_D0  = 4'b0011;
    localparam logic [3:0] P_D1  = 4'b1011;
    localparam logic [3:0] P_ACK = 4'b0010;
    localparam logic [3:0] P_NAK = 4'b1010;
`ifdef USB_TOGGLE_CHECK_EN
    localparam bit TOG_EN = 1'b1;
`else
    localparam bit TOG_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_l = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    bit   m_out_tog = 1'b0;
    bit   m_in_tog  = 1'b0;

    usb_device_xact_fsm_if bus ();

    usb_device_xact_fsm #(
        .DEV_ADDR       (DEV),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    wire logic [3:0]  obs_pulses = {bus.start_send_data, bus.start_send_hand,
                                    bus.wr_commit, bus.rd_commit};
    wire logic [11:0] obs_all    = {bus.start_send_data, bus.send_data_pid,
                                    bus.start_send_hand, bus.send_hand_pid,
                                    bus.wr_commit, bus.rd_commit};

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; strobes set before the call last exactly one cycle
    task automatic step();
        @(posedge clk);
        #1;
        bus.token_valid    = 1'b0;
        bus.data_valid     = 1'b0;
        bus.hand_valid     = 1'b0;
        bus.done_send_data = 1'b0;
        bus.done_send_hand = 1'b0;
    endtask

    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk(tag, 12'(obs_pulses), 12'h000);
        end
    endtask

    task automatic finish_hand(input string tag);
        int d;
        d = int'($urandom_range(0, 2));
        quiet({tag, "_hwait"}, d);
        bus.done_send_hand = 1'b1;
        step();
        chk({tag, "_hdone"}, 12'(obs_pulses), 12'h000);
    endtask

    task automatic out_xact(input logic [6:0] addr, input logic [3:0] dpid, input bit crc,
                            input bit rxr, input int w, input bit inject);
        bit         acc, exp_sh, exp_wr;
        logic [3:0] exp_hp;
        bus.rx_ready    = rxr;
        bus.token_valid = 1'b1;
        bus.token_pid   = P_OUT;
        bus.token_addr  = addr;
        step();
        chk("out_token", 12'(obs_pulses), 12'h000);
        for (int i = 1; i <= w; i++) begin
            if (inject && addr == DEV && i <= TO) begin
                bus.token_valid = 1'b1;
                bus.token_pid   = P_IN;
                bus.token_addr  = DEV;
                bus.tx_ready    = 1'b1;
            end
            step();
            chk("out_wait", 12'(obs_pulses), 12'h000);
        end
        bus.data_valid  = 1'b1;
        bus.data_pid    = dpid;
        bus.data_crc_ok = crc;
        step();
        acc    = (addr == DEV) && (w < TO);
        exp_sh = acc && crc;
        exp_wr = exp_sh && rxr && (!TOG_EN || dpid == (m_out_tog ? P_D1 : P_D0));
        exp_hp = rxr ? P_ACK : P_NAK;
        if (exp_wr) m_out_tog ^= TOG_EN;
        chk("out_data", 12'(obs_pulses), 12'({1'b0, exp_sh, exp_wr, 1'b0}));
        if (exp_sh) begin
            chk("out_hand_pid", 12'(bus.send_hand_pid), 12'(exp_hp));
            finish_hand("out");
        end
    endtask

    task automatic in_xact(input bit txr, input int wd, input int w, input bit ack, input bit inject);
        bit         exp_rd;
        logic [3:0] exp_dp;
        bus.tx_ready    = txr;
        bus.token_valid = 1'b1;
        bus.token_pid   = P_IN;
        bus.token_addr  = DEV;
        step();
        chk("in_token", 12'(obs_pulses), 12'({txr, !txr, 2'b00}));
        if (!txr) begin
            chk("in_nak_pid", 12'(bus.send_hand_pid), 12'(P_NAK));
            finish_hand("in_nak");
            return;
        end
        exp_dp = (TOG_EN && m_in_tog) ? P_D1 : P_D0;
        chk("in_data_pid", 12'(bus.send_data_pid), 12'(exp_dp));
        for (int i = 0; i < wd; i++) begin
            step();
            chk("in_txwait", 12'(obs_pulses), 12'h000);
            chk("in_pid_hold", 12'(bus.send_data_pid), 12'(exp_dp));
        end
        bus.done_send_data = 1'b1;
        step();
        chk("in_done", 12'(obs_pulses), 12'h000);
        for (int i = 1; i <= w; i++) begin
            if (inject && i <= TO) begin
                bus.token_valid = 1'b1;
                bus.token_pid   = P_IN;
                bus.token_addr  = DEV;
            end
            step();
            chk("in_wait", 12'(obs_pulses), 12'h000);
        end
        bus.hand_valid = 1'b1;
        bus.hand_pid   = ack ? P_ACK : P_NAK;
        step();
        exp_rd = (w < TO) && ack;
        if (exp_rd) m_in_tog ^= TOG_EN;
        chk("in_hand", 12'(obs_pulses), 12'({3'b000, exp_rd}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus.token_valid    = 1'b0;
        bus.token_pid      = '0;
        bus.token_addr     = '0;
        bus.data_valid     = 1'b0;
        bus.data_pid       = '0;
        bus.data_crc_ok    = 1'b0;
        bus.hand_valid     = 1'b0;
        bus.hand_pid       = '0;
        bus.rx_ready       = 1'b0;
        bus.tx_ready       = 1'b0;
        bus.done_send_data = 1'b0;
        bus.done_send_hand = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", obs_all, 12'h000);
        @(negedge clk) rst_l = 1'b1;
        step();
        chk("post_reset", obs_all, 12'h000);

        // OUT sequence: fresh DATA0, repeated DATA0, then DATA1
        out_xact(DEV, P_D0, 1'b1, 1'b1, 0, 1'b0);
        out_xact(DEV, P_D0, 1'b1, 1'b1, 1, 1'b0);
        out_xact(DEV, P_D1, 1'b1, 1'b1, 0, 1'b0);
        // IN with ACK, next IN, then a silent host, then the re-send
        in_xact(1'b1, 0, 0, 1'b1, 1'b0);
        in_xact(1'b1, 1, 2, 1'b1, 1'b0);
        in_xact(1'b1, 0, TO, 1'b1, 1'b0);
        in_xact(1'b1, 2, 0, 1'b0, 1'b0);
        in_xact(1'b1, 0, 1, 1'b1, 1'b0);
        // Error cases and boundaries
        out_xact(DEV, P_D0, 1'b0, 1'b1, 0, 1'b0);
        out_xact(DEV, P_D1, 1'b1, 1'b0, 0, 1'b0);
        in_xact(1'b0, 0, 0, 1'b1, 1'b0);
        out_xact(7'd6, P_D0, 1'b1, 1'b1, 0, 1'b0);
        out_xact(DEV, P_D0, 1'b1, 1'b1, TO - 1, 1'b1);
        out_xact(DEV, P_D1, 1'b1, 1'b1, TO, 1'b1);
        in_xact(1'b1, 0, TO - 1, 1'b1, 1'b1);

        bus.tx_ready    = 1'b1;
        bus.token_valid = 1'b1;
        bus.token_pid   = P_IN;
        bus.token_addr  = 7'd6;
        step();
        chk("in_misaddr", 12'(obs_pulses), 12'h000);
        bus.token_valid = 1'b1;
        bus.token_pid   = 4'b0101;
        bus.token_addr  = DEV;
        step();
        chk("bad_pid_token", 12'(obs_pulses), 12'h000);
        bus.rx_ready    = 1'b1;
        bus.data_valid  = 1'b1;
        bus.data_pid    = P_D0;
        bus.data_crc_ok = 1'b1;
        step();
        chk("data_in_idle", 12'(obs_pulses), 12'h000);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 0)
                out_xact(($urandom_range(0, 7) == 0) ? 7'd6 : DEV,
                         ($urandom_range(0, 1) == 1) ? P_D1 : P_D0,
                         $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                         int'($urandom_range(0, TO + 1)), $urandom_range(0, 1) == 1);
            else
                in_xact($urandom_range(0, 3) != 0, int'($urandom_range(0, 2)),
                        int'($urandom_range(0, TO + 1)), $urandom_range(0, 3) != 0,
                        $urandom_range(0, 1) == 1);
        end

        // Reset in the middle of an IN data phase
        bus.tx_ready    = 1'b1;
        bus.token_valid = 1'b1;
        bus.token_pid   = P_IN;
        bus.token_addr  = DEV;
        step();
        chk("rst_pre", 12'(obs_pulses), 12'h008);
        #2 rst_l = 1'b0;
        #1 chk("rst_async", obs_all, 12'h000);
        step();
        step();
        chk("rst_held", obs_all, 12'h000);
        @(negedge clk) rst_l = 1'b1;
        m_out_tog = 1'b0;
        m_in_tog  = 1'b0;
        quiet("rst_post", 3);
        bus.done_send_data = 1'b1;
        bus.done_send_hand = 1'b1;
        step();
        chk("stray_done", 12'(obs_pulses), 12'h000);
        in_xact(1'b1, 0, 0, 1'b1, 1'b0);
        out_xact(DEV, P_D0, 1'b1, 1'b1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
